timer_bank: RTL and testbench
=============================

// Module: timer_bank
// PURPOSE
//  Bank of NCH independent programmable timeout/period counters with a shared
//  prescaler. Each channel counts enabled prescaler strobes up to a limit, then
//  either latches an expiry flag (one-shot) or wraps and pulses (periodic).
//  It serves as the generic timing/timeout resource for pyrpl FSMs
//  (lock/relock timeouts, trigger hold-off, periodic sampling ticks).
// PARAMETERS
//  NCH  4   number of channels
//  CW   32  per-channel counter/limit width (bits)
//  PW   16  prescaler compare width (bits)
// PORTS
//  clk_i       in   1        ADC clock; all logic on rising edge
//  rstn_i      in   1        reset, synchronous, active-low
//  prescale_i  in   PW       strobe every prescale_i+1 cycles (0 = every cycle)
//  enable_i    in   NCH      per-channel count enable (level)
//  clear_i     in   NCH      per-channel clear (level, highest priority)
//  mode_i      in   NCH      0 = one-shot, 1 = periodic
//  limit_i     in   NCH*CW   per-channel limit N; ch k = [k*CW +: CW]
//  count_o     out  NCH*CW   per-channel current count
//  flag_o      out  NCH      sticky expiry flag
//  tick_o      out  NCH      1-cycle pulse per expiry event
//  irq_o       out  1        registered OR of flag_o
// BEHAVIOUR
//  - Reset (rstn_i=0 at edge): pcnt, count_o, flag_o, tick_o, irq_o all 0.
//  - Prescaler pcnt[PW-1:0] is free-running and ignores channel state.
//    If pcnt>=prescale_i: pcnt<=0 and stb=1. Otherwise pcnt<=pcnt+1, stb=0.
//    stb is combinational from pcnt.
//    prescale_i lowered below pcnt: the next edge strobes and restarts at 0.
//  - Per channel, priority order:
//    1 clear_i=1: count<=0, flag<=0, tick<=0 (regardless of enable and stb).
//    2 else if !(enable_i && stb): count and flag hold, tick<=0.
//    3 else if count<limit: count<=count+1, tick<=0.
//    4 else (count>=limit), i.e. expiry:
//      one-shot: count holds; flag<=1; tick<=1 only if flag was 0.
//      periodic: count<=0, flag<=1, tick<=1.
//  - Compare is >=, never ==. Lowering limit below count expires on the next
//    enabled strobe. count never exceeds max(limit at last increment).
//    No CW wrap is possible; limit=2^CW-1 is legal.
//  - Timing (prescale 0, enable held):
//    one-shot: flag rises N+1 cycles after the first enabled edge.
//    periodic: tick period is N+1 strobes. limit=0 ticks on every strobe.
//  - Changing mode_i takes effect at the next enabled strobe.
//    One-shot->periodic while flag=1: the next strobe wraps and ticks.
//  - Dropping enable_i freezes count; re-enabling resumes with no loss.
//  - Channels are fully independent. Simultaneous expiries on several channels
//    all tick in the same cycle.
//  - irq_o <= |flag (next-state), so it is coincident with flag_o.
//    It deasserts the cycle after the last clear.
//  - All outputs are registered. No combinational path from inputs to outputs.
// TESTING
//  1 Reset: rstn_i=0 for 3 cycles mid-count (count=5) -> all outputs 0 on the
//    next cycle; prescaler restarts at 0.
//  2 One-shot ch0: N=3, prescale=0, enable=1 -> count 1,2,3 then flag_o[0]=1
//    and tick_o[0] for exactly 1 cycle. count holds 3; no further ticks.
//  3 Periodic ch1: N=2, prescale=4 -> stb every 5 cycles; tick_o[1] every
//    15 cycles; count sequence 0,1,2,0...; flag_o[1] sticky.
//  4 Clear vs expiry: assert clear_i[0] on the same edge as expiry -> count=0,
//    flag=0, no tick. Clear held 10 cycles -> count stays 0.
//  5 Limit change: ch2 count=100, limit rewritten to 50, enable=1 -> expiry on
//    the next strobe. With limit=0 in periodic mode -> tick every strobe.
//  6 Multi-channel: 4 channels with N=7, same start -> all 4 ticks coincide.
//    irq_o=1 until every clear_i bit has pulsed; freezing enable on ch3 for
//    20 cycles delays only its flag by 20.

Source files
------------

// File: rtl/timer_bank.sv
// timer_bank: NCH independent timeout/period counters driven by one shared
// free-running prescaler strobe, with sticky expiry flags, tick pulses and an irq.
module timer_bank #(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int PW  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [PW-1:0]     prescale_i,
  input  logic [NCH-1:0]    enable_i,
  input  logic [NCH-1:0]    clear_i,
  input  logic [NCH-1:0]    mode_i,
  input  logic [NCH*CW-1:0] limit_i,
  output logic [NCH*CW-1:0] count_o,
  output logic [NCH-1:0]    flag_o,
  output logic [NCH-1:0]    tick_o,
  output logic              irq_o
);

  logic [PW-1:0]           pcnt;
  logic                    stb;
  logic [NCH-1:0][CW-1:0]  count_q;
  logic [NCH-1:0][CW-1:0]  count_n;
  logic [NCH-1:0]          flag_q;
  logic [NCH-1:0]          flag_n;
  logic [NCH-1:0]          tick_q;
  logic [NCH-1:0]          tick_n;
  logic                    irq_q;
  logic [CW-1:0]           lim;

  // Using >= lets a prescale value lowered below pcnt strobe immediately.
  assign stb = (pcnt >= prescale_i);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pcnt <= '0;
    end else if (stb) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_comb begin
    count_n = count_q;
    flag_n  = flag_q;
    tick_n  = '0;
    lim     = '0;
    for (int k = 0; k < NCH; k++) begin
      lim = limit_i[k*CW +: CW];
      if (clear_i[k]) begin
        count_n[k] = '0;
        flag_n[k]  = 1'b0;
      end else if (enable_i[k] && stb) begin
        if (count_q[k] < lim) begin
          count_n[k] = count_q[k] + 1'b1;
        end else if (mode_i[k]) begin
          count_n[k] = '0;
          flag_n[k]  = 1'b1;
          tick_n[k]  = 1'b1;
        end else begin
          // One-shot parks at the limit and only pulses on the first expiry.
          flag_n[k]  = 1'b1;
          tick_n[k]  = ~flag_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_q <= '0;
      flag_q  <= '0;
      tick_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_n;
      flag_q  <= flag_n;
      tick_q  <= tick_n;
      irq_q   <= |flag_n;
    end
  end

  assign count_o = count_q;
  assign flag_o  = flag_q;
  assign tick_o  = tick_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed scenarios plus randomized traffic for timer_bank,
// checked against a cycle-level behavioural model of the timer rules.
module tb_timer_bank;
  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int PW  = 16;

  logic              clk = 1'b0;
  logic              rstn_i;
  logic [PW-1:0]     prescale_i;
  logic [NCH-1:0]    enable_i;
  logic [NCH-1:0]    clear_i;
  logic [NCH-1:0]    mode_i;
  logic [NCH*CW-1:0] limit_i;
  logic [NCH*CW-1:0] count_o;
  logic [NCH-1:0]    flag_o;
  logic [NCH-1:0]    tick_o;
  logic              irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  longint m_pcnt = 0;
  longint m_count[NCH];
  bit     m_flag[NCH];
  bit     m_tick[NCH];
  bit     m_irq = 1'b0;

  timer_bank #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .prescale_i(prescale_i),
    .enable_i(enable_i), .clear_i(clear_i), .mode_i(mode_i),
    .limit_i(limit_i), .count_o(count_o), .flag_o(flag_o),
    .tick_o(tick_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  function automatic void model_update();
    bit strobe;
    longint lim;
    if (!rstn_i) begin
      m_pcnt = 0;
      m_irq  = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        m_count[k] = 0; m_flag[k] = 1'b0; m_tick[k] = 1'b0;
      end
      return;
    end
    strobe = (m_pcnt >= longint'(prescale_i));
    m_pcnt = strobe ? 0 : m_pcnt + 1;
    m_irq  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      lim = longint'(limit_i[k*CW +: CW]);
      m_tick[k] = 1'b0;
      if (clear_i[k]) begin
        m_count[k] = 0;
        m_flag[k]  = 1'b0;
      end else if (enable_i[k] && strobe) begin
        if (m_count[k] < lim) m_count[k] = m_count[k] + 1;
        else begin
          m_tick[k] = mode_i[k] ? 1'b1 : !m_flag[k];
          if (mode_i[k]) m_count[k] = 0;
          m_flag[k] = 1'b1;
        end
      end
      m_irq = m_irq | m_flag[k];
    end
  endfunction

  function automatic logic [NCH*CW+2*NCH:0] model_vec();
    logic [NCH*CW+2*NCH:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) begin
      v[2*NCH+1+k*CW +: CW] = m_count[k][CW-1:0];
      v[NCH+1+k] = m_flag[k];
      v[1+k]     = m_tick[k];
    end
    v[0] = m_irq;
    return v;
  endfunction

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_limit(input int k, input logic [CW-1:0] v);
    limit_i[k*CW +: CW] = v;
  endtask

  task automatic test_reset();
    clear_i = '1; enable_i = '0; mode_i = '0; prescale_i = '0; limit_i = '0;
    set_limit(0, 100);
    step();
    clear_i = '0; enable_i = 4'b0001;
    for (int i = 0; i < 5; i++) step();
    n_tests++;
    if (count_o[CW-1:0] !== CW'(5)) begin
      n_fail++; $display("[TB] FAIL reset_precount got %0d want 5", count_o[CW-1:0]);
    end
    prescale_i = 3;
    rstn_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({count_o, flag_o, tick_o, irq_o} !== '0) begin
        n_fail++; $display("[TB] FAIL reset_outputs got %h want 0", {count_o, flag_o, tick_o, irq_o});
      end
    end
    rstn_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 2 || i == 3) begin
        n_tests++;
        if (count_o[CW-1:0] !== CW'(i - 2)) begin
          n_fail++; $display("[TB] FAIL reset_prescaler_restart cyc %0d got %0d want %0d", i, count_o[CW-1:0], i - 2);
        end
      end
      n_tests++;
      if ({count_o, flag_o, tick_o, irq_o} !== model_vec()) begin
        n_fail++; $display("[TB] FAIL reset_model got %h want %h", {count_o, flag_o, tick_o, irq_o}, model_vec());
      end
    end
  endtask

  task automatic test_oneshot();
    int exp_c[6] = '{1, 2, 3, 3, 3, 3};
    bit exp_t[6] = '{0, 0, 0, 1, 0, 0};
    bit exp_f[6] = '{0, 0, 0, 1, 1, 1};
    clear_i = '1; enable_i = '0; mode_i = '0; prescale_i = '0;
    set_limit(0, 3);
    step();
    clear_i = '0; enable_i = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++;
      if (count_o[CW-1:0] !== CW'(exp_c[i]) || tick_o[0] !== exp_t[i] || flag_o[0] !== exp_f[i]) begin
        n_fail++;
        $display("[TB] FAIL oneshot cyc %0d got c=%0d t=%b f=%b want c=%0d t=%b f=%b",
                 i, count_o[CW-1:0], tick_o[0], flag_o[0], exp_c[i], exp_t[i], exp_f[i]);
      end
      n_tests++;
      if ({count_o, flag_o, tick_o, irq_o} !== model_vec()) begin
        n_fail++; $display("[TB] FAIL oneshot_model got %h want %h", {count_o, flag_o, tick_o, irq_o}, model_vec());
      end
    end
  endtask

  task automatic test_periodic();
    int last = -1;
    int nticks = 0;
    clear_i = '1; enable_i = '0; mode_i = 4'b0010; prescale_i = 4;
    set_limit(1, 2);
    step();
    clear_i = '0; enable_i = 4'b0010;
    for (int i = 0; i < 70; i++) begin
      step();
      if (tick_o[1]) begin
        nticks++;
        if (last >= 0) begin
          n_tests++;
          if (i - last != 15) begin
            n_fail++; $display("[TB] FAIL periodic_interval got %0d want 15", i - last);
          end
        end
        last = i;
      end
      n_tests++;
      if ({count_o, flag_o, tick_o, irq_o} !== model_vec()) begin
        n_fail++; $display("[TB] FAIL periodic_model got %h want %h", {count_o, flag_o, tick_o, irq_o}, model_vec());
      end
    end
    n_tests++;
    if (nticks < 4 || flag_o[1] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL periodic_ticks got %0d flag %b want >=4 flag 1", nticks, flag_o[1]);
    end
  endtask

  task automatic test_clear_vs_expiry();
    clear_i = '1; enable_i = '0; mode_i = '0; prescale_i = '0;
    set_limit(0, 3);
    step();
    clear_i = '0; enable_i = 4'b0001;
    for (int i = 0; i < 3; i++) step();
    clear_i = 4'b0001;
    for (int i = 0; i < 11; i++) begin
      step();
      n_tests++;
      if (count_o[CW-1:0] !== '0 || flag_o[0] !== 1'b0 || tick_o[0] !== 1'b0) begin
        n_fail++; $display("[TB] FAIL clear_vs_expiry cyc %0d got c=%0d f=%b t=%b want 0 0 0",
                           i, count_o[CW-1:0], flag_o[0], tick_o[0]);
      end
    end
    clear_i = '0;
  endtask

  task automatic test_limit_change();
    int nticks = 0;
    clear_i = '1; enable_i = '0; mode_i = '0; prescale_i = '0;
    set_limit(2, 200);
    step();
    clear_i = '0; enable_i = 4'b0100;
    for (int i = 0; i < 100; i++) step();
    n_tests++;
    if (count_o[2*CW +: CW] !== CW'(100)) begin
      n_fail++; $display("[TB] FAIL limit_precount got %0d want 100", count_o[2*CW +: CW]);
    end
    set_limit(2, 50);
    step();
    n_tests++;
    if (flag_o[2] !== 1'b1 || tick_o[2] !== 1'b1 || count_o[2*CW +: CW] !== CW'(100)) begin
      n_fail++; $display("[TB] FAIL limit_lowered got f=%b t=%b c=%0d want 1 1 100",
                         flag_o[2], tick_o[2], count_o[2*CW +: CW]);
    end
    mode_i = 4'b0100; prescale_i = 2;
    set_limit(2, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick_o[2]) nticks++;
      n_tests++;
      if ({count_o, flag_o, tick_o, irq_o} !== model_vec()) begin
        n_fail++; $display("[TB] FAIL limit_model got %h want %h", {count_o, flag_o, tick_o, irq_o}, model_vec());
      end
    end
    n_tests++;
    if (nticks != 4 || count_o[2*CW +: CW] !== '0) begin
      n_fail++; $display("[TB] FAIL limit_zero_ticks got %0d c=%0d want 4 c=0", nticks, count_o[2*CW +: CW]);
    end
  endtask

  task automatic test_multi();
    int rise[NCH];
    clear_i = '1; enable_i = '0; mode_i = '0; prescale_i = '0;
    for (int k = 0; k < NCH; k++) set_limit(k, 7);
    step();
    clear_i = '0; enable_i = '1;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_tests++;
      if (tick_o !== ((i == 8) ? 4'hF : 4'h0)) begin
        n_fail++; $display("[TB] FAIL multi_tick cyc %0d got %b want %b", i, tick_o, (i == 8) ? 4'hF : 4'h0);
      end
    end
    enable_i = '0;
    for (int k = 0; k < NCH; k++) begin
      clear_i = 4'(1 << k);
      step();
      clear_i = '0;
      n_tests++;
      if (irq_o !== (k < NCH - 1)) begin
        n_fail++; $display("[TB] FAIL multi_irq after clear %0d got %b want %b", k, irq_o, k < NCH - 1);
      end
    end
    clear_i = '1;
    step();
    clear_i = '0; enable_i = '1;
    for (int k = 0; k < NCH; k++) rise[k] = -1;
    for (int i = 1; i <= 40; i++) begin
      enable_i = (i > 2 && i <= 22) ? 4'b0111 : 4'b1111;
      step();
      for (int k = 0; k < NCH; k++) if (flag_o[k] && rise[k] < 0) rise[k] = i;
      n_tests++;
      if ({count_o, flag_o, tick_o, irq_o} !== model_vec()) begin
        n_fail++; $display("[TB] FAIL multi_model got %h want %h", {count_o, flag_o, tick_o, irq_o}, model_vec());
      end
    end
    n_tests++;
    if (rise[0] != 8 || rise[1] != 8 || rise[2] != 8 || rise[3] != 28) begin
      n_fail++; $display("[TB] FAIL multi_freeze got %0d %0d %0d %0d want 8 8 8 28",
                         rise[0], rise[1], rise[2], rise[3]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rstn_i     = ($urandom_range(0, 99) != 0);
      prescale_i = PW'($urandom_range(0, 3));
      enable_i   = NCH'($urandom);
      for (int k = 0; k < NCH; k++) begin
        clear_i[k] = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 19) == 0) mode_i[k] = ~mode_i[k];
        if ($urandom_range(0, 9) == 0) set_limit(k, CW'($urandom_range(0, 9)));
      end
      step();
      n_tests++;
      if ({count_o, flag_o, tick_o, irq_o} !== model_vec()) begin
        n_fail++; $display("[TB] FAIL random cyc %0d got %h want %h", i, {count_o, flag_o, tick_o, irq_o}, model_vec());
      end
    end
    rstn_i = 1'b1;
  endtask

  initial begin
    rstn_i = 1'b0; prescale_i = '0; enable_i = '0; clear_i = '0; mode_i = '0; limit_i = '0;
    step();
    step();
    rstn_i = 1'b1;
    test_reset();
    test_oneshot();
    test_periodic();
    test_clear_vs_expiry();
    test_limit_change();
    test_multi();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
